// File: rtl/or_frame_acc.sv
// Frame OR-accumulator: ORs accepted words into one result per frame of
// frame_len beats (or until flush), then holds the result until downstream takes it.
module or_frame_acc #(
   parameter int W  = 8,
   parameter int LW = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   input  logic [W-1:0]  in_data,
   output logic          in_ready,
   input  logic [LW-1:0] frame_len,
   input  logic          flush,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [W-1:0]  out_data,
   output logic [LW:0]   out_count,
   output logic          out_full
);

   typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;

   localparam logic [LW:0] CNT_ONE = (LW+1)'(1);

   state_t        state_reg, state_next;
   logic [W-1:0]  acc_reg, acc_next;
   logic [LW:0]   cnt_reg, cnt_next;
   logic [LW:0]   len_reg, len_next;
   logic [LW:0]   cnt_inc;
   logic          accept;

   assign in_ready = (state_reg != HOLD);
   assign accept   = in_valid & in_ready;
   assign cnt_inc  = cnt_reg + CNT_ONE;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
         acc_reg   <= '0;
         cnt_reg   <= '0;
         len_reg   <= '0;
      end else begin
         state_reg <= state_next;
         acc_reg   <= acc_next;
         cnt_reg   <= cnt_next;
         len_reg   <= len_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      acc_next   = acc_reg;
      cnt_next   = cnt_reg;
      len_next   = len_reg;
      case (state_reg)
         IDLE: begin
            if (accept) begin
               acc_next   = in_data;
               cnt_next   = CNT_ONE;
               // A zero frame_len widens to 2^LW through the extra MSB.
               len_next   = {(frame_len == '0), frame_len};
               state_next = (len_next == CNT_ONE) ? HOLD : ACC;
            end
         end
         ACC: begin
            if (accept) begin
               acc_next = acc_reg | in_data;
               cnt_next = cnt_inc;
               if ((cnt_inc == len_reg) || flush)
                  state_next = HOLD;
            end else if (flush) begin
               state_next = HOLD;
            end
         end
         HOLD: begin
            if (out_ready) begin
               state_next = IDLE;
               acc_next   = '0;
               cnt_next   = '0;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign out_valid = (state_reg == HOLD);
   assign out_data  = out_valid ? acc_reg : '0;
   assign out_count = out_valid ? cnt_reg : '0;
   assign out_full  = out_valid & (&acc_reg);

endmodule

// File: tb/tb_or_frame_acc.sv
// Bench for or_frame_acc: directed frames plus random traffic, each cycle
// compared against a queue-based frame model.
module tb_or_frame_acc;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic [7:0] in_data;
   logic       in_ready;
   logic [3:0] frame_len;
   logic       flush;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_data;
   logic [4:0] out_count;
   logic       out_full;

   int n_checks = 0;
   int n_errors = 0;

   // Model: words of the frame being built, the frame target, and whether a result is pending.
   logic [7:0] m_words[$];
   int         m_target = 0;
   bit         m_hold   = 1'b0;

   or_frame_acc #(.W(8), .LW(4)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .frame_len(frame_len), .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_count(out_count), .out_full(out_full)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic logic [7:0] model_or();
      logic [7:0] r = 8'h00;
      foreach (m_words[i]) r = r | m_words[i];
      return r;
   endfunction

   task automatic compare_all(input string tag);
      logic [7:0] e_data;
      e_data = m_hold ? model_or() : 8'h00;
      check({tag, "_in_ready"},  32'(in_ready),  32'(!m_hold));
      check({tag, "_out_valid"}, 32'(out_valid), 32'(m_hold));
      check({tag, "_out_data"},  32'(out_data),  32'(e_data));
      check({tag, "_out_count"}, 32'(out_count), m_hold ? 32'(m_words.size()) : 32'd0);
      check({tag, "_out_full"},  32'(out_full),  32'(m_hold && (e_data == 8'hFF)));
   endtask

   // One clock: drive inputs, advance the model by the frame rules, compare after the edge.
   task automatic cycle(input string tag, input logic v, input logic [7:0] d, input logic fl,
                        input logic [3:0] flen, input logic ordy, input logic r);
      rst = r; in_valid = v; in_data = d; flush = fl; frame_len = flen; out_ready = ordy;
      if (r) begin
         m_words.delete(); m_hold = 1'b0;
      end else if (m_hold) begin
         if (ordy) begin
            m_hold = 1'b0; m_words.delete();
         end
      end else if (v) begin
         if (m_words.size() == 0) begin
            m_target = (flen == 0) ? 16 : int'(flen);
            m_words.push_back(d);
            if (m_words.size() == m_target) m_hold = 1'b1;
         end else begin
            m_words.push_back(d);
            if (m_words.size() == m_target || fl) m_hold = 1'b1;
         end
      end else if (fl && m_words.size() > 0) begin
         m_hold = 1'b1;
      end
      @(posedge clk);
      #1;
      compare_all(tag);
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_data = '0; flush = 1'b0; frame_len = '0; out_ready = 1'b0;
      cycle("reset", 0, 8'h00, 0, 0, 0, 1);
      cycle("reset", 0, 8'h00, 0, 0, 0, 1);

      // Three-beat frame, result available right after the last beat.
      cycle("f3", 1, 8'hF0, 0, 3, 1, 0);
      cycle("f3", 1, 8'h00, 0, 3, 1, 0);
      cycle("f3", 1, 8'hAA, 0, 3, 1, 0);
      check("f3_result", 32'(out_data), 32'hFA);
      check("f3_count",  32'(out_count), 32'd3);
      cycle("f3", 0, 8'h00, 0, 3, 1, 0);
      check("f3_idle", 32'(out_valid), 32'd0);

      // Back-pressured full result with in_valid asserted against a stalled block.
      cycle("bp", 1, 8'hF0, 0, 2, 0, 0);
      cycle("bp", 1, 8'h0F, 0, 2, 0, 0);
      for (int i = 0; i < 5; i++) cycle("bp_hold", 1, 8'h33, 0, 2, 0, 0);
      check("bp_full", 32'(out_full), 32'd1);
      cycle("bp", 0, 8'h00, 0, 2, 1, 0);

      // Sixteen-beat frame with gaps; frame_len changed mid-frame.
      for (int i = 0; i < 16; i++) begin
         cycle("f16", 1, 8'h01, 0, (i == 0) ? 4'd0 : 4'd3, 0, 0);
         if (i % 3 == 1) cycle("f16_gap", 0, 8'hFF, 0, 4'd2, 0, 0);
      end
      check("f16_count", 32'(out_count), 32'd16);
      check("f16_data",  32'(out_data),  32'h01);
      cycle("f16", 0, 8'h00, 0, 0, 1, 0);

      // Flush together with the third beat.
      cycle("fl", 1, 8'h11, 0, 5, 0, 0);
      cycle("fl", 1, 8'h22, 0, 5, 0, 0);
      cycle("fl", 1, 8'h44, 1, 5, 0, 0);
      check("fl_count", 32'(out_count), 32'd3);
      check("fl_data",  32'(out_data),  32'h77);
      cycle("fl", 0, 8'h00, 0, 5, 1, 0);

      // Flush without a beat, and flush ignored on the first beat.
      cycle("fl2", 1, 8'h80, 1, 4, 0, 0);
      cycle("fl2", 0, 8'h00, 1, 4, 0, 0);
      check("fl2_count", 32'(out_count), 32'd1);
      cycle("fl2", 0, 8'h00, 0, 4, 1, 0);

      // Reset mid-frame discards it.
      cycle("rst_mid", 1, 8'h12, 0, 4, 0, 0);
      cycle("rst_mid", 1, 8'h34, 0, 4, 0, 0);
      cycle("rst_mid", 0, 8'h00, 0, 4, 0, 1);
      cycle("f1", 1, 8'hA5, 0, 1, 0, 0);
      check("f1_data", 32'(out_data), 32'hA5);
      cycle("f1", 0, 8'h00, 0, 1, 1, 0);

      // Single-beat frames back to back: one result every two cycles.
      for (int i = 0; i < 6; i++) cycle("b2b", 1, 8'(i + 1), 0, 1, 1, 0);

      // Random traffic.
      for (int i = 0; i < 3000; i++) begin
         cycle("rnd", ($urandom_range(0, 9) < 7), 8'($urandom), ($urandom_range(0, 9) == 0),
               4'($urandom), ($urandom_range(0, 1) == 1), ($urandom_range(0, 99) == 0));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/or_frame_acc.md
OR_FRAME_ACC -- requirements
Module: or_frame_acc

Interface
REQ-001 Parameter W, default 8, data width of input words and result.
REQ-002 Parameter LW, default 4, width of frame_len; maximum frame length is 2^LW beats.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 in_valid  input  1  upstream word present on in_data.
REQ-006 in_data  input  W  word to be OR-accumulated.
REQ-007 in_ready  output  1  block can accept a word this cycle.
REQ-008 frame_len  input  LW  beats per frame; sampled only on the first beat of a frame; 0 means 2^LW.
REQ-009 flush  input  1  close the current frame early.
REQ-010 out_valid  output  1  out_data/out_count hold a completed frame result.
REQ-011 out_ready  input  1  downstream accepts the result.
REQ-012 out_data  output  W  bitwise OR of all words accepted in the frame.
REQ-013 out_count  output  LW+1  number of beats accepted in the frame (1..2^LW).
REQ-014 out_full  output  1  out_data is all ones; valid only with out_valid.

Function
REQ-015 The block SHALL implement FSM states IDLE, ACC, HOLD.
REQ-016 A beat is accepted iff in_valid and in_ready are both 1 at a rising edge.
REQ-017 in_ready SHALL be 1 in IDLE and ACC, 0 in HOLD; out_valid SHALL be 1 only in HOLD.
REQ-018 IDLE, beat accepted: acc <= in_data, cnt <= 1, len <= frame_len (0 -> 2^LW); next state HOLD if len==1, else ACC.
REQ-019 IDLE without accepted beat: remain IDLE, acc and cnt unchanged; flush ignored.
REQ-020 ACC, beat accepted: acc <= acc | in_data, cnt <= cnt+1; next state HOLD if cnt+1 == len, else ACC.
REQ-021 ACC, flush=1 and no beat: next state HOLD with acc/cnt unchanged (partial frame).
REQ-022 ACC, flush=1 with accepted beat: beat SHALL be included, then HOLD.
REQ-023 ACC, no beat and no flush: hold state and data indefinitely.
REQ-024 HOLD: out_data=acc, out_count=cnt, out_full=(acc == all ones), all stable until handshake.
REQ-025 HOLD, out_ready=1: next state IDLE; acc and cnt cleared to 0; in_valid ignored this cycle; flush ignored in HOLD.
REQ-026 Latency: out_valid SHALL assert the cycle after the last beat (or flush) is registered; one bubble cycle in IDLE-accept path is not permitted beyond the HOLD->IDLE transition.
REQ-027 frame_len changes during ACC or HOLD SHALL NOT affect the current frame.
REQ-028 cnt SHALL be LW+1 bits so 2^LW is representable without wrap; cnt never exceeds len.
REQ-029 X on in_data of a non-accepted cycle SHALL NOT alter acc.

Reset
REQ-030 rst=1 at a rising edge SHALL force IDLE, acc=0, cnt=0, len=0 regardless of state, including mid-frame and in HOLD.
REQ-031 During and after reset: in_ready=1, out_valid=0, out_data=0, out_count=0, out_full=0.
REQ-032 A frame in progress at reset SHALL be discarded; no result emitted.

Verification
REQ-033 frame_len=3, beats 8'b11110000, 8'b00000000, 8'b10101010, out_ready=1 -> out_valid one cycle after third beat, out_data=8'b11111010, out_count=3, out_full=0, IDLE next cycle.
REQ-034 frame_len=2, beats 8'hF0, 8'h0F, out_ready held 0 for 5 cycles -> out_valid stays 1, out_data=8'hFF, out_full=1, in_ready=0 throughout; released on out_ready.
REQ-035 frame_len=0 (16 beats), 16 beats of 8'h01 with in_valid gaps -> out_count=16, out_data=8'h01.
REQ-036 frame_len=5, beats 8'h11, 8'h22, flush with third beat 8'h44 -> out_count=3, out_data=8'h77.
REQ-037 frame_len=4, two beats accepted, rst=1 for one cycle -> IDLE, all outputs 0; new frame frame_len=1, beat 8'hA5 -> out_data=8'hA5, out_count=1.
REQ-038 frame_len=1, back-to-back beats with out_ready=1 -> one result per two cycles, second beat stalled by in_ready=0 in HOLD.
